// File: rtl/alu_pkg.sv
// Shared opcode and controller state encodings for the accumulator ALU,
// plus a reference ALU function used by the parent and by simulation.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SHL     = 3'b001,
        OP_XNOR    = 3'b010,
        OP_SHR     = 3'b011,
        OP_LOAD    = 3'b100,
        OP_STORE   = 3'b101,
        OP_NEGATE  = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_FIRE    = 3'd2,
        S_CAPTURE = 3'd3,
        S_STORE   = 3'd4
    } state_e;

    localparam int DATA_W = 8;

    // Returns {e, result}. Shifts, load and negate act on DR; add and xnor combine AC with DR.
    function automatic logic [DATA_W:0] alu_compute(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] dr,
        input logic [DATA_W-1:0] ac
    );
        logic [DATA_W:0] r;
        case (op)
            OP_ADD:    r = {1'b0, ac} + {1'b0, dr};
            OP_SHL:    r = {dr[DATA_W-1], dr[DATA_W-2:0], 1'b0};
            OP_XNOR:   r = {1'b0, ~(ac ^ dr)};
            OP_SHR:    r = {dr[0], 1'b0, dr[DATA_W-1:1]};
            OP_LOAD:   r = {1'b0, dr};
            OP_NEGATE: r = {1'b0, (~dr) + 8'd1};
            default:   r = {1'b0, ac};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Sequencing controller for an external accumulator ALU: accepts one
// instruction at a time, fires the ALU, captures AC/E, and handles stores.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [7:0] instr_operand,
    output logic [2:0] mode,
    output logic       activate,
    output logic [7:0] dr_out,
    output logic [7:0] ac_out,
    input  logic [7:0] alu_result,
    input  logic       alu_e,
    output logic       e_flag,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic       done,
    output logic       err
);

    state_e     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [7:0] dr_q, dr_d;
    logic [7:0] ac_q, ac_d;
    logic       e_q, e_d;
    logic       activate_q, activate_d;
    logic       mem_we_q, mem_we_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dr_d       = dr_q;
        ac_d       = ac_q;
        e_d        = e_q;
        activate_d = 1'b0;
        mem_we_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    mode_d = instr_op;
                    dr_d   = instr_operand;
                    if (instr_op == OP_STORE) begin
                        state_d  = S_STORE;
                        mem_we_d = 1'b1;
                    end else if (instr_op == OP_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            // SETUP gives mode/dr_out a full stable cycle before activate rises.
            S_SETUP: begin
                state_d    = S_FIRE;
                activate_d = 1'b1;
            end
            S_FIRE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                ac_d    = alu_result;
                e_d     = alu_e;
                done_d  = 1'b1;
            end
            S_STORE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 3'b000;
            dr_q       <= 8'h00;
            ac_q       <= 8'h00;
            e_q        <= 1'b0;
            activate_q <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dr_q       <= dr_d;
            ac_q       <= ac_d;
            e_q        <= e_d;
            activate_q <= activate_d;
            mem_we_q   <= mem_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign mode        = mode_q;
    assign activate    = activate_q;
    assign dr_out      = dr_q;
    assign ac_out      = ac_q;
    assign e_flag      = e_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = ac_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural ALU beside it.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [7:0] instr_operand;
    logic [2:0] mode;
    logic       activate;
    logic [7:0] dr_out;
    logic [7:0] ac_out;
    logic [7:0] alu_result;
    logic       alu_e;
    logic       e_flag;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    int         act_cnt, done_cnt, err_cnt, we_cnt, done_idx, err_idx, ready_idx;
    logic [7:0] we_data, ac_mid;

    alu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_operand(instr_operand),
        .mode         (mode),
        .activate     (activate),
        .dr_out       (dr_out),
        .ac_out       (ac_out),
        .alu_result   (alu_result),
        .alu_e        (alu_e),
        .e_flag       (e_flag),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb {alu_e, alu_result} = alu_compute(mode, dr_out, ac_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Offer one instruction, drop it after the accept edge, then watch 8 cycles.
    task automatic exec(input logic [2:0] op, input logic [7:0] val);
        @(negedge clk);
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_operand = val;
        @(posedge clk);
        #1;
        instr_valid   = 1'b0;
        instr_operand = 8'hA5;
        act_cnt = 0; done_cnt = 0; err_cnt = 0; we_cnt = 0;
        done_idx = -1; err_idx = -1; we_data = 8'h00; ac_mid = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (activate) act_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (err) begin
                err_cnt++;
                if (err_idx < 0) err_idx = i;
            end
            if (mem_we) begin
                we_cnt++;
                we_data = mem_wdata;
            end
            if (i == 2) ac_mid = ac_out;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_op      = 3'b000;
        instr_operand = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_act", activate, 0);
        check("rst_mode", mode, 0);
        check("rst_dr", dr_out, 0);
        check("rst_ac", ac_out, 0);
        check("rst_e", e_flag, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", mem_we, 0);
        rst_n = 1'b1;

        // Load 0x3C
        exec(OP_LOAD, 8'h3C);
        check("load_ac", ac_out, 8'h3C);
        check("load_e", e_flag, 0);
        check("load_mode", mode, 3'b100);
        check("load_dr", dr_out, 8'h3C);
        check("load_act_cnt", act_cnt, 1);
        check("load_done_cnt", done_cnt, 1);
        check("load_done_idx", done_idx, 3);
        check("load_ac_before", ac_mid, 8'h00);
        check("load_we_cnt", we_cnt, 0);

        // AC=0xF0, add 0x20 -> 0x10 with carry
        exec(OP_LOAD, 8'hF0);
        check("ldf0_ac", ac_out, 8'hF0);
        exec(OP_ADD, 8'h20);
        check("add_ac", ac_out, 8'h10);
        check("add_e", e_flag, 1);
        check("add_ac_before", ac_mid, 8'hF0);
        check("add_done_idx", done_idx, 3);

        // xnor and shl
        exec(OP_LOAD, 8'h0F);
        exec(OP_XNOR, 8'h33);
        check("xnor_ac", ac_out, 8'hC3);
        check("xnor_e", e_flag, 0);
        exec(OP_SHL, 8'h81);
        check("shl_ac", ac_out, 8'h02);
        check("shl_e", e_flag, 1);

        // Store AC=0x55
        exec(OP_LOAD, 8'h55);
        exec(OP_STORE, 8'h99);
        check("st_we_cnt", we_cnt, 1);
        check("st_wdata", we_data, 8'h55);
        check("st_act_cnt", act_cnt, 0);
        check("st_ac", ac_out, 8'h55);
        check("st_e", e_flag, 0);
        check("st_done_cnt", done_cnt, 1);
        check("st_done_idx", done_idx, 1);

        // AC=0x55 + 0xF0 -> 0x45, E=1; then illegal leaves both alone
        exec(OP_ADD, 8'hF0);
        check("add2_ac", ac_out, 8'h45);
        check("add2_e", e_flag, 1);
        exec(OP_ILLEGAL, 8'h12);
        check("ill_err_cnt", err_cnt, 1);
        check("ill_err_idx", err_idx, 0);
        check("ill_done_cnt", done_cnt, 0);
        check("ill_act_cnt", act_cnt, 0);
        check("ill_ac", ac_out, 8'h45);
        check("ill_e", e_flag, 1);

        // Reset asserted during FIRE
        @(negedge clk);
        instr_valid   = 1'b1;
        instr_op      = OP_LOAD;
        instr_operand = 8'h77;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fire_act", activate, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstfire_act", activate, 0);
        check("rstfire_ac", ac_out, 8'h00);
        check("rstfire_ready", instr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        act_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (activate) act_cnt++;
            if (done) done_cnt++;
        end
        check("rstfire_post_act", act_cnt, 0);
        check("rstfire_post_done", done_cnt, 0);
        check("rstfire_post_ac", ac_out, 8'h00);

        // Back-to-back negate 0x01 then shr 0x80, instr_valid held high while busy
        @(negedge clk);
        instr_valid   = 1'b1;
        instr_op      = OP_NEGATE;
        instr_operand = 8'h01;
        @(posedge clk);
        #1;
        instr_op      = OP_SHR;
        instr_operand = 8'h80;
        ready_idx = -1;
        act_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (activate) act_cnt++;
            if (i == 1) begin
                check("b2b_busy_mode", mode, 3'b110);
                check("b2b_busy_dr", dr_out, 8'h01);
            end
            if (instr_ready) begin
                ready_idx = i;
                break;
            end
        end
        check("b2b_ready_idx", ready_idx, 3);
        check("b2b_neg_ac", ac_out, 8'hFF);
        check("b2b_neg_done", done, 1);
        check("b2b_neg_act_cnt", act_cnt, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        done_idx = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done && done_idx < 0) done_idx = i;
        end
        check("b2b_shr_done_idx", done_idx, 3);
        check("b2b_shr_ac", ac_out, 8'h40);
        check("b2b_shr_e", e_flag, 0);
        check("b2b_shr_mode", mode, 3'b011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
